// File: rtl/aes_key_sched_iter_pkg.sv
// rtl/aes_key_sched_iter_pkg.sv - shared types, round constants and S-box for the AES-128 key schedule.
package aes_key_sched_iter_pkg;

  localparam int NR_DEFAULT = 10;
  localparam int KEY_W      = 128;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXPAND   = 2'd1,
    ST_EMIT_FWD = 2'd2,
    ST_EMIT_REV = 2'd3
  } state_t;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Indices past the table yield zero; they only occur on paths that are never committed.
  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_key_sched_iter_round.sv
// rtl/aes_key_sched_iter_round.sv - one AES-128 key schedule step, forward or inverse.
// Both directions share a single 4-byte SubWord; only its input word differs.
module aes_key_round
  import aes_key_sched_iter_pkg::*;
(
  input  logic             inv,
  input  logic [7:0]       rcon,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw_in, rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_in;

  // The inverse needs the previous w3, which is recoverable as w3' ^ w2'.
  assign sw_in = inv ? (w3 ^ w2) : w3;
  assign rot   = {sw_in[23:0], sw_in[31:24]};
  assign t     = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                 ^ {rcon, 24'h0};

  always_comb begin
    if (!inv) begin
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ t;
    end
  end

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_sched_iter.sv
// rtl/aes_key_sched_iter.sv - iterative AES-128 round key generator with ascending or descending emission.
module aes_key_sched_iter
  import aes_key_sched_iter_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inv,
  input  logic [3:0]       round_sel,
  input  logic [KEY_W-1:0] key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] key_out,
  output logic [3:0]       out_round,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  localparam logic [3:0] NR_SEL = 4'(NR);

  state_t           state, state_nxt;
  logic [3:0]       r, r_nxt;
  logic [3:0]       sel, sel_nxt;
  logic [KEY_W-1:0] key, key_nxt, key_step;
  logic             err_nxt;
  logic             step_inv;
  logic [3:0]       rcon_idx;
  logic [7:0]       rcon_val;
  logic             hs;

  // Descending emission walks back using the constant that produced the current key.
  assign step_inv = (state == ST_EMIT_REV);
  assign rcon_idx = step_inv ? (r - 4'd1) : r;
  assign rcon_val = rcon_byte(rcon_idx);
  assign hs       = out_valid && out_ready;

  aes_key_round u_round (
    .inv     (step_inv),
    .rcon    (rcon_val),
    .key_in  (key),
    .key_out (key_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      r     <= 4'd0;
      sel   <= 4'd0;
      key   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      sel   <= sel_nxt;
      key   <= key_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    sel_nxt   = sel;
    key_nxt   = key;
    err_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (round_sel > NR_SEL) begin
            err_nxt = 1'b1;
          end else begin
            key_nxt = key_in;
            r_nxt   = 4'd0;
            sel_nxt = round_sel;
            if (!inv)                   state_nxt = ST_EMIT_FWD;
            else if (round_sel != 4'd0) state_nxt = ST_EXPAND;
            else                        state_nxt = ST_EMIT_REV;
          end
        end
      end
      ST_EXPAND: begin
        key_nxt = key_step;
        r_nxt   = r + 4'd1;
        if ((r + 4'd1) == sel) state_nxt = ST_EMIT_REV;
      end
      ST_EMIT_FWD: begin
        if (hs) begin
          if (r == sel) begin
            state_nxt = ST_IDLE;
          end else begin
            key_nxt = key_step;
            r_nxt   = r + 4'd1;
          end
        end
      end
      ST_EMIT_REV: begin
        if (hs) begin
          if (r == 4'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            key_nxt = key_step;
            r_nxt   = r - 4'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them without waiting for a clock.
  always_comb begin
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_EMIT_FWD) || (state == ST_EMIT_REV);
    key_out   = out_valid ? key : '0;
    out_round = out_valid ? r : 4'd0;
    out_last  = 1'b0;
    if (state == ST_EMIT_FWD) out_last = (r == sel);
    if (state == ST_EMIT_REV) out_last = (r == 4'd0);
  end

endmodule
